// File: rtl/branch_resolve_ctrl_if.sv
// branch_resolve_ctrl_if
//   Groups the EX-stage resolution inputs, the redirect/flush outputs, the
//   predictor update handshake and the statistics outputs of
//   branch_resolve_ctrl.
//   master : pipeline/predictor side (drives EX inputs and upd_ready)
//   slave  : branch_resolve_ctrl (drives redirect, flush, upd_*, counters)
interface branch_resolve_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             ex_valid;
  logic             ex_is_ctrl;
  logic             ex_stall;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_pred_pc;
  logic [31:0]      ex_actual_pc;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             upd_valid;
  logic             upd_ready;
  logic [31:0]      upd_addr;
  logic [31:0]      upd_next_pc;
  logic             upd_wrong;
  logic             q_full;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  logic [7:0]       drop_cnt;

  modport master (
    output ex_valid, ex_is_ctrl, ex_stall, ex_pc, ex_pred_pc, ex_actual_pc, upd_ready,
    input  redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
           upd_valid, upd_addr, upd_next_pc, upd_wrong, q_full,
           branch_cnt, mispred_cnt, drop_cnt
  );

  modport slave (
    input  ex_valid, ex_is_ctrl, ex_stall, ex_pc, ex_pred_pc, ex_actual_pc, upd_ready,
    output redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
           upd_valid, upd_addr, upd_next_pc, upd_wrong, q_full,
           branch_cnt, mispred_cnt, drop_cnt
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
//   Resolves the control-flow instruction in EX against its fetch-time
//   prediction. A mispredict produces a one-cycle redirect plus IF/ID and
//   ID/EX flush. Every resolved outcome is queued in a DEPTH-entry FIFO that
//   feeds the gshare predictor's update port, and branch/mispredict/drop
//   statistics are kept.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of branch_resolve_ctrl_if (EX inputs, redirect and
//              flush outputs, predictor update handshake, counters)
module branch_resolve_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_ctrl_if.slave bus
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               ev_s;
  logic               mis_s;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic               drop_s;
  logic [31:0]        redirect_pc_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W:0]     count_r;
  logic [31:0]        addr_mem_r  [DEPTH];
  logic [31:0]        npc_mem_r   [DEPTH];
  logic               wrong_mem_r [DEPTH];
  logic [CNT_W-1:0]   branch_cnt_r;
  logic [CNT_W-1:0]   mispred_cnt_r;
  logic [7:0]         drop_cnt_r;

  // Event decode and FIFO push/pop qualification
  always_comb begin
    ev_s    = bus.ex_valid & bus.ex_is_ctrl & ~bus.ex_stall & (state_r == IDLE);
    mis_s   = ev_s & (bus.ex_pred_pc != bus.ex_actual_pc);
    full_s  = (count_r == FULL_CNT);
    empty_s = (count_r == {(PTR_W + 1){1'b0}});
    pop_s   = ~empty_s & bus.upd_ready;
    // When full, a push only fits if the head leaves in the same cycle.
    push_s  = ev_s & (~full_s | pop_s);
    drop_s  = ev_s & full_s & ~pop_s;
  end

  // Next-state logic: RECOVER is a single-cycle pulse after a mispredict
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (mis_s) state_nxt_s = RECOVER;
        else       state_nxt_s = IDLE;
      end
      RECOVER: state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and redirect target capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      redirect_pc_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      if (mis_s) redirect_pc_r <= bus.ex_actual_pc;
    end
  end

  // FIFO storage; contents need no reset because reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      addr_mem_r[wr_ptr_r]  <= bus.ex_pc;
      npc_mem_r[wr_ptr_r]   <= bus.ex_actual_pc;
      wrong_mem_r[wr_ptr_r] <= mis_s;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Statistics counters; drop_cnt saturates, the others wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_r  <= {CNT_W{1'b0}};
      mispred_cnt_r <= {CNT_W{1'b0}};
      drop_cnt_r    <= 8'h00;
    end else begin
      if (ev_s)  branch_cnt_r  <= branch_cnt_r + 1'b1;
      if (mis_s) mispred_cnt_r <= mispred_cnt_r + 1'b1;
      if (drop_s && (drop_cnt_r != 8'hFF)) drop_cnt_r <= drop_cnt_r + 8'h01;
    end
  end

  assign bus.redirect_valid = (state_r == RECOVER);
  assign bus.flush_if_id    = (state_r == RECOVER);
  assign bus.flush_id_ex    = (state_r == RECOVER);
  assign bus.redirect_pc    = redirect_pc_r;
  assign bus.q_full         = full_s;
  assign bus.upd_valid      = ~empty_s;
  // Head fields are forced to 0 when empty so uninitialised storage never shows.
  assign bus.upd_addr       = empty_s ? 32'h0000_0000 : addr_mem_r[rd_ptr_r];
  assign bus.upd_next_pc    = empty_s ? 32'h0000_0000 : npc_mem_r[rd_ptr_r];
  assign bus.upd_wrong      = empty_s ? 1'b0 : wrong_mem_r[rd_ptr_r];
  assign bus.branch_cnt     = branch_cnt_r;
  assign bus.mispred_cnt    = mispred_cnt_r;
  assign bus.drop_cnt       = drop_cnt_r;

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequences the gshare branch predictor from the EX stage of the 5-stage pipeline. Each cycle it checks the resolved control-flow instruction in EX against the PC that was predicted at fetch. On a mismatch it issues a one-cycle PC redirect and flushes the younger stages. It also queues resolved outcomes in a small FIFO and feeds them to the predictor's synchronous update port, one per accepted handshake. It keeps branch and mispredict statistics counters.

Parameters:
DEPTH, 4, update FIFO entries (power of two, >= 2)
CNT_W, 32, width of branch_cnt and mispred_cnt

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
ex_valid  in  1  EX holds a valid instruction this cycle
ex_is_ctrl  in  1  EX instruction is a branch or jump
ex_stall  in  1  EX is held by the hazard unit; no resolution this cycle
ex_pc  in  32  PC of the EX instruction
ex_pred_pc  in  32  next-PC predicted at fetch, carried down the pipe
ex_actual_pc  in  32  resolved next-PC
redirect_valid  out  1  load redirect_pc into the PC register
redirect_pc  out  32  correct fetch target
flush_if_id  out  1  squash the IF/ID register
flush_id_ex  out  1  squash the ID/EX register
upd_valid  out  1  FIFO head is valid (predictor update_pred)
upd_ready  in  1  predictor accepts the head this cycle
upd_addr  out  32  head branch address (branch_inst_address)
upd_next_pc  out  32  head resolved next-PC (resolved_next_pc)
upd_wrong  out  1  head was mispredicted (predictor_wrong)
q_full  out  1  FIFO holds DEPTH entries
branch_cnt  out  CNT_W  resolved control instructions
mispred_cnt  out  CNT_W  mispredicted control instructions
drop_cnt  out  8  events lost to a full FIFO, saturates at 255

Behaviour:
- Resolution event E = ex_valid & ex_is_ctrl & ~ex_stall & (state == IDLE). Mispredict M = E & (ex_pred_pc != ex_actual_pc).
- FSM states: IDLE, RECOVER.
  - IDLE -> RECOVER on M. State, redirect_pc <= ex_actual_pc and the other outputs are registered at the edge ending the event cycle.
  - RECOVER lasts exactly one cycle. In it: redirect_valid = flush_if_id = flush_id_ex = 1, redirect_pc holds the target. Next state is IDLE unconditionally.
  - During RECOVER, EX holds a wrong-path instruction. E is forced to 0, so nothing is pushed or counted.
- In IDLE, redirect_valid, flush_if_id and flush_id_ex are 0. redirect_pc holds its last value (0 after reset).
- A correct prediction never leaves IDLE. Back-to-back correct events are accepted every cycle.
- FIFO:
  - Push on E, entry {ex_pc, ex_actual_pc, M}.
  - Pop on upd_valid & upd_ready. The head is driven combinationally from storage, so upd_* are 0-latency after the entry is written.
  - First-word latency: an event in cycle N appears on upd_* in cycle N+1.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is count 0..DEPTH.
  - Empty: upd_valid = 0. upd_addr, upd_next_pc and upd_wrong are don't-care and not checked.
  - Full with push and no pop: the push is dropped and drop_cnt increments (saturating). The event is still counted in branch_cnt and mispred_cnt, and M still triggers RECOVER.
  - Full with push and pop in the same cycle: both occur and count stays DEPTH.
  - Empty with push and upd_ready: no bypass. The entry is written and popped no earlier than the next cycle.
- Counters:
  - branch_cnt += E.
  - mispred_cnt += M.
  - Both wrap modulo 2^CNT_W.
- Reset (any cycle, including during RECOVER or with a non-empty FIFO):
  - State = IDLE; pointers and count = 0; all counters = 0; redirect_pc = 0.
  - All outputs are 0 in the cycle after the reset edge.
  - The in-flight redirect is discarded and stored entries are lost.
  - Inputs are ignored while rst is high.

Test Plan:
1. Correct branch: ex_pc=0x100, pred=actual=0x200, upd_ready=1 -> no redirect or flush; next cycle upd_valid=1, upd_addr=0x100, upd_next_pc=0x200, upd_wrong=0; branch_cnt=1, mispred_cnt=0.
2. Mispredict: ex_pc=0x40, pred=0x44, actual=0x80 -> next cycle redirect_valid=flush_if_id=flush_id_ex=1 and redirect_pc=0x80 for exactly one cycle; a ctrl instruction in EX during that cycle is not counted or queued; upd_wrong=1; mispred_cnt=1.
3. Backpressure: upd_ready=0 with 5 correct events in consecutive cycles, DEPTH=4 -> q_full=1 after the 4th event; 5th dropped with drop_cnt=1, branch_cnt=5; then upd_ready=1 drains addresses in push order over 4 cycles.
4. Full with simultaneous push and pop: FIFO full, upd_ready=1, new event -> head popped, new entry at the tail, q_full stays 1, drop_cnt unchanged.
5. ex_stall=1 with a valid ctrl instruction for 3 cycles, then released -> exactly one event recorded.
6. rst asserted during RECOVER with 2 entries queued -> next cycle all outputs and counters 0, upd_valid=0; a new event after reset is accepted normally.
